// File: rtl/mvm_pkg.sv
// Shared types, default dimensions and flat-bus offset helpers for the
// matrix-vector streaming controller.
package mvm_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_B = 3'd2,
    EVAL   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  // Default geometry and timing.
  localparam int MVM_X          = 4;
  localparam int MVM_H          = 4;
  localparam int MVM_DATA_WIDTH = 8;
  localparam int MVM_EVAL_CYC   = 2;

  // Bit offset of weight element (m,n) in the row-major weight bus.
  function automatic int a_off(input int m, input int n, input int x, input int dw);
    return ((m * x) + n) * dw;
  endfunction

  // Bit offset of element n in the vector bus or row n in the result bus.
  function automatic int v_off(input int n, input int dw);
    return n * dw;
  endfunction

  // Shared counter width: wide enough for every weight index and the
  // settle count, whichever is larger.
  function automatic int cnt_width(input int x, input int h, input int eval_cyc);
    int top;
    top = (x * h > eval_cyc) ? x * h : eval_cyc;
    return $clog2(top + 1);
  endfunction

endpackage

// File: rtl/mvm_stream_ctrl.sv
// Streaming front/back end for the combinational matrix-vector engine.
// Collects weights (optional) and vector words over valid/ready, presents
// them on registered flat operand buses, waits a fixed settle time,
// captures the engine result rows and streams them out over valid/ready.
module mvm_stream_ctrl
  import mvm_pkg::*;
#(
  parameter int X          = MVM_X,
  parameter int H          = MVM_H,
  parameter int DATA_WIDTH = MVM_DATA_WIDTH,
  parameter int EVAL_CYC   = MVM_EVAL_CYC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         load_w,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic [0:X*H*DATA_WIDTH-1]    a_flat,
  output logic [0:X*DATA_WIDTH-1]      b_flat,
  input  logic [0:H*DATA_WIDTH-1]      c_flat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_last,
  output logic                         busy
);

  localparam int NW = X * H;
  localparam int CW = cnt_width(X, H, EVAL_CYC);
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  localparam logic [CW-1:0] W_LAST = CW'(NW - 1);
  localparam logic [CW-1:0] B_LAST = CW'(X - 1);
  localparam logic [CW-1:0] E_LAST = CW'(EVAL_CYC - 1);
  localparam logic [RW-1:0] R_LAST = RW'(H - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_cnt;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_a_mem  [NW];
  logic [DATA_WIDTH-1:0] r_b_mem  [X];
  logic [DATA_WIDTH-1:0] r_result [H];

  logic w_in_ready;
  logic w_in_hs;
  logic w_out_valid;
  logic w_out_hs;
  logic w_a_we;
  logic w_b_we;
  logic w_capture;

  // Handshake and write-enable decode, all from registered state.
  assign w_in_ready  = (r_state == LOAD_W) || (r_state == LOAD_B);
  assign w_in_hs     = in_valid && w_in_ready;
  assign w_out_valid = (r_state == DRAIN);
  assign w_out_hs    = w_out_valid && out_ready;
  assign w_a_we      = (r_state == LOAD_W) && w_in_hs;
  assign w_b_we      = (r_state == LOAD_B) && w_in_hs;
  assign w_capture   = (r_state == EVAL) && (r_cnt == E_LAST);

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_result[r_row];
  assign out_last  = w_out_valid && (r_row == R_LAST);
  assign busy      = (r_state != IDLE);

  // Next-state decode; start/load_w only matter in IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = load_w ? LOAD_W : LOAD_B;
        end
      end
      LOAD_W: begin
        if (w_in_hs && (r_cnt == W_LAST)) begin
          w_state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        if (w_in_hs && (r_cnt == B_LAST)) begin
          w_state_next = EVAL;
        end
      end
      EVAL: begin
        if (w_capture) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_out_hs && (r_row == R_LAST)) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Shared slot / settle counter: cleared on every state change, advanced
  // per accepted word while loading and per cycle while settling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_state_next != r_state) begin
      r_cnt <= '0;
    end else if (w_in_hs || (r_state == EVAL)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Output row pointer; advances only on an accepted result word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row <= '0;
    end else if (r_state != DRAIN) begin
      r_row <= '0;
    end else if (w_out_hs) begin
      r_row <= (r_row == R_LAST) ? '0 : r_row + 1'b1;
    end
  end

  // Weight store: written only by a weight-loading job, otherwise retained.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) begin
        r_a_mem[i] <= '0;
      end
    end else if (w_a_we) begin
      for (int i = 0; i < NW; i++) begin
        if (r_cnt == CW'(i)) begin
          r_a_mem[i] <= in_data;
        end
      end
    end
  end

  // Vector store: rewritten by every job.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < X; i++) begin
        r_b_mem[i] <= '0;
      end
    end else if (w_b_we) begin
      for (int i = 0; i < X; i++) begin
        if (r_cnt == CW'(i)) begin
          r_b_mem[i] <= in_data;
        end
      end
    end
  end

  // Result capture at the end of the settle window.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < H; i++) begin
        r_result[i] <= '0;
      end
    end else if (w_capture) begin
      for (int i = 0; i < H; i++) begin
        r_result[i] <= c_flat[v_off(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  // Flatten the operand stores onto the engine buses (element 0 at bit 0).
  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_a_bus
      assign a_flat[a_off(gi / X, gi % X, X, DATA_WIDTH) +: DATA_WIDTH] = r_a_mem[gi];
    end
    for (genvar gi = 0; gi < X; gi++) begin : g_b_bus
      assign b_flat[v_off(gi, DATA_WIDTH) +: DATA_WIDTH] = r_b_mem[gi];
    end
  endgenerate

endmodule

// File: tb/tb_mvm_stream_ctrl.sv
// Directed bench for mvm_stream_ctrl with a behavioural engine stub:
// result row m = a(m,0) XOR b(0).
module tb_mvm_stream_ctrl;
  import mvm_pkg::*;

  localparam int X  = 4;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int EC = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              load_w;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic [0:X*H*DW-1] a_flat;
  logic [0:X*DW-1]   b_flat;
  logic [0:H*DW-1]   c_flat;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;

  always #5 clk = ~clk;

  mvm_stream_ctrl #(.X(X), .H(H), .DATA_WIDTH(DW), .EVAL_CYC(EC)) dut (
    .clk(clk), .rst(rst), .start(start), .load_w(load_w),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .a_flat(a_flat), .b_flat(b_flat), .c_flat(c_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  // Engine stub.
  always_comb begin
    c_flat = '0;
    for (int m = 0; m < H; m++) begin
      c_flat[m*DW +: DW] = a_flat[(m*X)*DW +: DW] ^ b_flat[0 +: DW];
    end
  end

  // Input handshake monitor.
  always @(posedge clk) begin
    if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word after `gap` idle cycles (garbage data while idle).
  task automatic send(input logic [DW-1:0] d, input int gap);
    logic hs;
    int   t;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'hEE;
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    hs = 1'b0;
    while (!hs && t < 20) begin
      hs = in_ready;
      tick();
      t++;
    end
    in_valid = 1'b0;
    in_data  = 8'hEE;
    if (!hs) check_eq("in_hs_timeout", 0, 1);
  endtask

  task automatic pulse_start(input logic lw);
    start  = 1'b1;
    load_w = lw;
    tick();
    start  = 1'b0;
    load_w = 1'b0;
  endtask

  // Count edges from the accepting edge of the last word to out_valid.
  task automatic measure_latency(input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq("latency", lat, exp_lat);
  endtask

  // Collect H result words; optional backpressure on one row, optional
  // start raised together with the final handshake.
  task automatic drain(input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                       input logic [DW-1:0] e2, input logic [DW-1:0] e3,
                       input int bp_row, input logic start_on_last, output int cycles);
    logic [DW-1:0] exp_w [H];
    int t;
    exp_w[0] = e0; exp_w[1] = e1; exp_w[2] = e2; exp_w[3] = e3;
    cycles = 0;
    out_ready = 1'b1;
    for (int r = 0; r < H; r++) begin
      t = 0;
      while (!out_valid && t < 20) begin
        tick();
        t++;
        cycles++;
      end
      check_eq($sformatf("out_data_r%0d", r), out_data, exp_w[r]);
      check_eq($sformatf("out_last_r%0d", r), out_last, (r == H-1));
      if (r == bp_row) begin
        out_ready = 1'b0;
        for (int b = 0; b < 5; b++) begin
          tick();
          cycles++;
          check_eq($sformatf("bp_hold_data_c%0d", b), out_data, exp_w[r]);
          check_eq($sformatf("bp_hold_valid_c%0d", b), out_valid, 1);
        end
        out_ready = 1'b1;
      end
      if (r == H-1 && start_on_last) begin
        start  = 1'b1;
        load_w = 1'b1;
      end
      tick();
      cycles++;
    end
  endtask

  logic [0:X*H*DW-1] exp_a;
  int base;
  int dcyc;

  initial begin
    rst = 1'b1; start = 1'b0; load_w = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    // Reset
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_a_flat", a_flat, 0);
    check_eq("rst_b_flat", b_flat, 0);

    // Job 1: weights with stalled input, then vector
    pulse_start(1'b1);
    check_eq("j1_busy", busy, 1);
    check_eq("j1_in_ready", in_ready, 1);
    base = hs_cnt;
    for (int k = 0; k < X*H; k++) begin
      send(8'(k + 1), (k % 2));
      exp_a[k*DW +: DW] = 8'(k + 1);
    end
    check_eq("j1_a_1_2", a_flat[a_off(1, 2, X, DW) +: DW], 8'h07);
    check_eq("j1_a_flat", a_flat, exp_a);
    for (int n = 0; n < X; n++) send(8'(8'hA0 + n), 0);
    check_eq("j1_b_slot3", b_flat[3*DW +: DW], 8'hA3);
    check_eq("j1_b_slot0", b_flat[0 +: DW], 8'hA0);
    check_eq("j1_hs_count", hs_cnt - base, X*H + X);
    check_eq("j1_in_ready_eval", in_ready, 0);
    measure_latency(EC + 1);
    drain(8'hA1, 8'hA5, 8'hA9, 8'hAD, 1, 1'b0, dcyc);
    check_eq("j1_idle", busy, 0);

    // Job 2: vector only, weights kept; start while busy ignored
    pulse_start(1'b0);
    base = hs_cnt;
    send(8'h0F, 0);
    pulse_start(1'b1);
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    check_eq("j2_hs_count", hs_cnt - base, X);
    check_eq("j2_a_kept", a_flat, exp_a);
    check_eq("j2_b_flat", b_flat, {8'h0F, 8'h00, 8'h00, 8'h00});
    measure_latency(EC + 1);
    drain(8'h0E, 8'h0A, 8'h06, 8'h02, -1, 1'b1, dcyc);
    check_eq("j2_drain_cycles", dcyc, H);
    check_eq("j2_start_in_last_ignored", busy, 0);
    // start still high: accepted now that IDLE has been entered
    tick();
    start = 1'b0;
    load_w = 1'b0;
    check_eq("j3_busy", busy, 1);
    check_eq("j3_in_ready", in_ready, 1);

    // Job 3: abort by reset after 7 weights
    for (int k = 0; k < 7; k++) send(8'h55, 0);
    check_eq("j3_partial_a", a_flat[0 +: DW], 8'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_in_ready", in_ready, 0);
    check_eq("abort_a_flat", a_flat, 0);
    check_eq("abort_b_flat", b_flat, 0);
    check_eq("abort_out_data", out_data, 0);
    tick();
    check_eq("abort_still_idle", busy, 0);

    // Job 4: vector only after abort, weights are zero
    pulse_start(1'b0);
    for (int n = 0; n < X; n++) send(8'(8'hA0 + n), 0);
    measure_latency(EC + 1);
    drain(8'hA0, 8'hA0, 8'hA0, 8'hA0, -1, 1'b0, dcyc);
    check_eq("j4_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
